// File: rtl/addsub_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : addsub_pkg
// Brief   : Shared types for the bit-serial adder/subtractor.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package addsub_pkg;

  // Default operand width of the serial adder/subtractor.
  localparam int ADDSUB_DEFAULT_N = 8;

  // Bit counter width for the default operand width.
  localparam int ADDSUB_CNT_W = $clog2(ADDSUB_DEFAULT_N);

  // Bit counter type for the default operand width.
  typedef logic [ADDSUB_CNT_W-1:0] count_t;

  // Controller states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bit counter width for an arbitrary operand width.
  // A width of at least 1 is always returned so the counter is never empty.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/adder1.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : adder1
// Brief   : One-bit full adder cell, used as the serial bit-slice.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module adder1 (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  // Plain full-adder equations.
  always_comb begin
    sum   = a ^ b ^ c_in;
    c_out = (a & b) | (a & c_in) | (b & c_in);
  end

endmodule : adder1
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : serial_addsub
// Brief   : Bit-serial N-bit adder/subtractor with valid/ready handshakes.
//           One bit per clock through a single full-adder cell; subtraction
//           is A + ~B + 1 with the +1 injected as the initial carry.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int N = ADDSUB_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         c_out,
  output logic         overflow
);

  localparam int              CNT_W    = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

  state_t             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [N-1:0]       sa_q;
  logic [N-1:0]       sb_q;
  logic               carry_q;
  logic [CNT_W-1:0]   count_q;
  logic [N-1:0]       result_q;
  logic               c_out_q;
  logic               overflow_q;

  logic               sum_bit;
  logic               bit_carry;

  // Single bit-slice: LSBs of the operand shifters plus the carry flop.
  adder1 u_adder1 (
    .a     (sa_q[0]),
    .b     (sb_q[0]),
    .c_in  (carry_q),
    .sum   (sum_bit),
    .c_out (bit_carry)
  );

  // Controller and datapath: operand capture, serial shift, result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sa_q        <= '0;
      sb_q        <= '0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      result_q    <= '0;
      c_out_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            // B is inverted here for subtraction; the +1 rides in carry.
            sa_q       <= a;
            sb_q       <= sub ? ~b : b;
            carry_q    <= sub;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end

        S_RUN: begin
          // Sum bits enter from the MSB side so the first (LSB) sum bit
          // ends up in result[0] after N shifts.
          result_q <= {sum_bit, result_q[N-1:1]};
          sa_q     <= {1'b0, sa_q[N-1:1]};
          sb_q     <= {1'b0, sb_q[N-1:1]};
          carry_q  <= bit_carry;
          count_q  <= count_q + CNT_W'(1);
          if (count_q == LAST_BIT) begin
            // carry_q is the carry into the MSB, bit_carry the carry out.
            c_out_q     <= bit_carry;
            overflow_q  <= carry_q ^ bit_carry;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end

        S_DONE: begin
          // in_ready only rises after this edge, so no same-cycle turnover.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign c_out     = c_out_q;
  assign overflow  = overflow_q;

endmodule : serial_addsub
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_serial_addsub
// Brief   : Self-checking bench for serial_addsub (N = 8) with a scoreboard.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_serial_addsub;

  localparam int N = 8;

  typedef struct {
    logic [N-1:0] r;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         c_out;
  logic         overflow;

  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];

  serial_addsub #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .c_out     (c_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Independent reference: full-width add with explicit sign-rule overflow.
  function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
    exp_t         e;
    logic [N-1:0] yy;
    logic [N:0]   full;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {{N{1'b0}}, s};
    e.r  = full[N-1:0];
    e.c  = full[N];
    e.o  = (x[N-1] == yy[N-1]) && (e.r[N-1] != x[N-1]);
    return e;
  endfunction

  // Wait for in_ready, present operands for one edge; caller is #1 after an edge.
  task automatic start_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
    int waited;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    a        = x;
    b        = y;
    sub      = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = ~x;
    b        = ~y;
    sub      = ~s;
    check("in_ready_after_accept", in_ready, 0);
  endtask

  // Wait for the result, compare against the scoreboard, then handshake.
  task automatic finish_op(input string tag, input bit chk_lat, input int bp_cycles);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (!out_valid && cyc < N + 6) begin
      check({tag, "_in_ready_busy"}, in_ready, 0);
      @(posedge clk); #1;
      cyc++;
    end
    if (chk_lat) check({tag, "_latency"}, cyc, N);
    check({tag, "_out_valid"}, out_valid, 1);
    e = sb_q.pop_front();
    check({tag, "_result"}, result, e.r);
    check({tag, "_c_out"}, c_out, e.c);
    check({tag, "_overflow"}, overflow, e.o);
    // Backpressure: outputs must hold while new operands are offered.
    for (int k = 0; k < bp_cycles; k++) begin
      in_valid = ~in_valid;
      a        = N'($urandom_range(0, 255));
      b        = N'($urandom_range(0, 255));
      sub      = ~sub;
      @(posedge clk); #1;
      check({tag, "_bp_result"}, result, e.r);
      check({tag, "_bp_c_out"}, c_out, e.c);
      check({tag, "_bp_overflow"}, overflow, e.o);
      check({tag, "_bp_in_ready"}, in_ready, 0);
      check({tag, "_bp_out_valid"}, out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_out_valid_cleared"}, out_valid, 0);
    check({tag, "_in_ready_restored"}, in_ready, 1);
  endtask

  // Directed vector with hand-computed expectations.
  task automatic run_fixed(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                           input logic s, input logic [N-1:0] er, input logic ec,
                           input logic eo, input bit chk_lat);
    exp_t e;
    e.r = er;
    e.c = ec;
    e.o = eo;
    start_op(x, y, s);
    sb_q.push_back(e);
    finish_op(tag, chk_lat, 0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_c_out", c_out, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // Directed vectors from hand arithmetic.
    run_fixed("add_3_5",     8'd3,   8'd5,   1'b0, 8'd8,   1'b0, 1'b0, 1'b1);
    run_fixed("add_200_100", 8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0, 1'b1);
    run_fixed("sub_5_3",     8'd5,   8'd3,   1'b1, 8'd2,   1'b1, 1'b0, 1'b1);
    run_fixed("sub_3_5",     8'd3,   8'd5,   1'b1, 8'd254, 1'b0, 1'b0, 1'b1);
    run_fixed("add_127_1",   8'd127, 8'd1,   1'b0, 8'd128, 1'b0, 1'b1, 1'b1);
    run_fixed("sub_128_1",   8'd128, 8'd1,   1'b1, 8'd127, 1'b1, 1'b1, 1'b1);
    run_fixed("sub_0_0",     8'd0,   8'd0,   1'b1, 8'd0,   1'b1, 1'b0, 1'b0);
    run_fixed("add_0_0",     8'd0,   8'd0,   1'b0, 8'd0,   1'b0, 1'b0, 1'b0);

    // Backpressure, then a follow-up op must still be correct.
    start_op(8'd77, 8'd99, 1'b1);
    sb_q.push_back(model(8'd77, 8'd99, 1'b1));
    finish_op("bp", 1'b1, 5);
    run_fixed("after_bp",    8'd40,  8'd2,   1'b0, 8'd42,  1'b0, 1'b0, 1'b1);

    // Randomised operands against the reference model.
    for (int i = 0; i < 8; i++) begin
      logic [N-1:0] x;
      logic [N-1:0] y;
      logic         s;
      x = N'($urandom_range(0, 255));
      y = N'($urandom_range(0, 255));
      s = 1'($urandom_range(0, 1));
      start_op(x, y, s);
      sb_q.push_back(model(x, y, s));
      finish_op("rand", 1'b0, (i == 3) ? 2 : 0);
    end

    // Asynchronous reset while the serial run is at count 3.
    start_op(8'd255, 8'd255, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_result", result, 0);
    check("abort_c_out", c_out, 0);
    check("abort_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_in_ready", in_ready, 1);
    begin
      int spurious;
      spurious = 0;
      for (int k = 0; k < N + 3; k++) begin
        if (out_valid) spurious++;
        @(posedge clk); #1;
      end
      check("abort_no_spurious_valid", spurious, 0);
    end
    run_fixed("fresh_10_20", 8'd10, 8'd20, 1'b0, 8'd30, 1'b0, 1'b0, 1'b1);

    check("scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time guard so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule : tb_serial_addsub
`default_nettype wire
